// File: rtl/mul_arb2.sv
// Two-requester round-robin front end for a shared sequential signed 4x4 multiplier.
// Each accepted operand pair is issued once and answered with a result or a timeout error.
module mul_arb2 #(
   parameter int TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       req0_ready,
   output logic       req1_ready,
   output logic       rsp0_valid,
   output logic       rsp1_valid,
   output logic [7:0] rsp_result,
   output logic       rsp_err,
   output logic       mul_start,
   output logic [3:0] mul_a,
   output logic [3:0] mul_b,
   input  logic [7:0] mul_result,
   input  logic       mul_done,
   output logic       busy
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_r;
   logic            last_r;
   logic            gnt_r;
   logic [CW-1:0]   cnt_r;
   logic            grant_s;
   logic            any_s;

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      any_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_r;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign req0_ready = (state_r == IDLE) & req0_valid & ~grant_s;
   assign req1_ready = (state_r == IDLE) & req1_valid &  grant_s;

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         last_r     <= 1'b1;
         gnt_r      <= 1'b0;
         cnt_r      <= '0;
         mul_start  <= 1'b0;
         mul_a      <= 4'd0;
         mul_b      <= 4'd0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= 8'd0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         mul_start  <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  gnt_r     <= grant_s;
                  last_r    <= grant_s;
                  mul_a     <= grant_s ? req1_a : req0_a;
                  mul_b     <= grant_s ? req1_b : req0_b;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_r   <= '0;
               state_r <= WAIT;
            end
            WAIT: begin
               // Done wins over expiry when both land in the final WAIT cycle.
               if (mul_done || (cnt_r == CW'(TIMEOUT - 1))) begin
                  rsp_result <= mul_done ? mul_result : 8'd0;
                  rsp_err    <= ~mul_done;
                  mul_a      <= 4'd0;
                  mul_b      <= 4'd0;
                  rsp0_valid <= ~gnt_r;
                  rsp1_valid <= gnt_r;
                  state_r    <= RESP;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            RESP: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               mul_a   <= 4'd0;
               mul_b   <= 4'd0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arb2.sv
// Directed bench for mul_arb2: a cycle-stepped multiplier model plus a response scoreboard.
module tb_mul_arb2;

   localparam int TO = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, mul_start, busy;
   logic [7:0] rsp_result;
   logic [3:0] mul_a, mul_b;
   logic [7:0] mul_result = 8'd0;
   logic       mul_done = 1'b0;
   logic       stray = 1'b0;

   typedef struct {
      int         idx;
      logic [7:0] res;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0, miscompares = 0;
   int         cyc = 0, rsp_cnt = 0, start_cnt = 0, start_cyc = 0, last_gap = 0;
   int         cd = 0, model_lat = 1;
   logic [7:0] sb_last_res = 8'd0;

   mul_arb2 #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_done(mul_done), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
      logic signed [7:0] p;
      p = $signed(a) * $signed(b);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock step: check any response against the scoreboard, then advance the multiplier model.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (rsp0_valid || rsp1_valid) begin
         rsp_cnt++;
         last_gap = cyc - start_cyc;
         if (sb.size() == 0) begin
            chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_idx", {30'd0, rsp1_valid, rsp0_valid}, (e.idx != 0) ? 32'd2 : 32'd1);
            chk("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            if (!e.err) chk("rsp_after_done", {31'd0, mul_done}, 32'd1);
            sb_last_res = e.res;
         end
      end
      mul_done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            mul_done   = 1'b1;
            mul_result = prod(mul_a, mul_b);
         end
      end
      if (stray) begin
         mul_done   = 1'b1;
         mul_result = 8'hAA;
      end
      if (mul_start) begin
         start_cnt++;
         start_cyc = cyc;
         cd        = model_lat;
      end
      #1;
   endtask

   task automatic wait_accept(input int exp_idx, input logic exp_err);
      int         got;
      exp_t       e;
      logic [3:0] a, b;
      got = -1;
      for (int i = 0; i < 100 && got < 0; i++) begin
         #1;
         if (req0_valid && req0_ready) got = 0;
         else if (req1_valid && req1_ready) got = 1;
         if (got < 0) tick();
      end
      if (got < 0) begin
         chk("accept_timeout", {30'd0, req1_ready, req0_ready}, (exp_idx != 0) ? 32'd2 : 32'd1);
         return;
      end
      chk("grant", got, exp_idx);
      chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      a     = (got != 0) ? req1_a : req0_a;
      b     = (got != 0) ? req1_b : req0_b;
      e.idx = got;
      e.err = exp_err;
      e.res = exp_err ? 8'd0 : prod(a, b);
      sb.push_back(e);
      tick();
      chk("mul_start_pulse", {31'd0, mul_start}, 32'd1);
      chk("busy_issue", {31'd0, busy}, 32'd1);
      chk("ready_off", {31'd0, req0_ready | req1_ready}, 32'd0);
      chk("mul_a_issue", {28'd0, mul_a}, {28'd0, a});
      chk("mul_b_issue", {28'd0, mul_b}, {28'd0, b});
   endtask

   task automatic wait_rsp();
      int target;
      target = rsp_cnt + 1;
      for (int i = 0; i < 100 && rsp_cnt < target; i++) tick();
      if (rsp_cnt < target) chk("rsp_timeout", {30'd0, rsp1_valid, rsp0_valid}, 32'd3);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
      tick();
   endtask

   initial begin
      int n;
      int s;

      // Reset values
      do_reset();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
      chk("rst_mul_ab", {24'd0, mul_a, mul_b}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_ready_idle", {30'd0, req1_ready, req0_ready}, 32'd0);

      // Single request -3 * -7
      s = start_cnt;
      model_lat = 3;
      req0_a = 4'hD; req0_b = 4'h9; req0_valid = 1'b1;
      wait_accept(0, 1'b0);
      req0_valid = 1'b0;
      tick();
      chk("single_start_once", {31'd0, mul_start}, 32'd0);
      chk("single_mul_a_hold", {28'd0, mul_a}, 32'hD);
      chk("single_mul_b_hold", {28'd0, mul_b}, 32'h9);
      wait_rsp();
      chk("single_result", {24'd0, rsp_result}, 32'h15);
      chk("single_mul_a_clear", {28'd0, mul_a}, 32'd0);
      chk("single_start_count", start_cnt - s, 1);

      // Simultaneous requests from reset, round-robin over six grants
      do_reset();
      req0_a = 4'h7; req0_b = 4'h8; req1_a = 4'h2; req1_b = 4'h3;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         model_lat = 1 + (i % 3);
         wait_accept(i % 2, 1'b0);
         wait_rsp();
         chk("rr_result", {24'd0, rsp_result}, (i % 2 != 0) ? 32'h06 : 32'hC8);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Timeout: multiplier never answers
      model_lat = -1;
      req1_a = 4'h3; req1_b = 4'h3; req1_valid = 1'b1;
      wait_accept(1, 1'b1);
      req1_valid = 1'b0;
      wait_rsp();
      chk("timeout_gap", last_gap, TO + 1);
      chk("timeout_err", {31'd0, rsp_err}, 32'd1);

      // Done on the last WAIT cycle counts as done
      model_lat = TO;
      req0_a = 4'h2; req0_b = 4'h5; req0_valid = 1'b1;
      wait_accept(0, 1'b0);
      req0_valid = 1'b0;
      wait_rsp();
      chk("late_done_gap", last_gap, TO + 1);
      chk("late_done_result", {24'd0, rsp_result}, 32'h0A);

      // Reset during WAIT, multiplier answers afterwards
      model_lat = 8;
      req0_a = 4'h1; req0_b = 4'h1; req0_valid = 1'b1;
      wait_accept(0, 1'b0);
      req0_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      n = rsp_cnt;
      repeat (10) tick();
      chk("midrst_no_rsp", rsp_cnt, n);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_result", {24'd0, rsp_result}, 32'd0);
      model_lat = 2;
      req0_a = 4'hF; req0_b = 4'h4; req1_a = 4'h5; req1_b = 4'h5;
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_accept(0, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp();
      chk("midrst_next_result", {24'd0, rsp_result}, 32'hFC);

      // Stray done while IDLE
      tick();
      n = rsp_cnt;
      s = start_cnt;
      stray = 1'b1;
      tick();
      tick();
      stray = 1'b0;
      tick();
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_no_rsp", rsp_cnt, n);
      chk("stray_no_start", start_cnt, s);
      chk("stray_hold_result", {24'd0, rsp_result}, {24'd0, sb_last_res});
      model_lat = 2;
      req1_a = 4'h8; req1_b = 4'h8; req1_valid = 1'b1;
      wait_accept(1, 1'b0);
      req1_valid = 1'b0;
      wait_rsp();
      chk("final_result", {24'd0, rsp_result}, 32'h40);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
